disp_window_driver: RTL

DISP_WINDOW_DRIVER -- requirements
Module: disp_window_driver

---
 rtl/disp_window_driver_pkg.sv | 29 ++
 rtl/disp_timing_gen.sv | 71 +++++++
 rtl/disp_window_driver.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/disp_window_driver_pkg.sv
// Shared colours, colour-bar table and 1080p60 raster timing for the display window driver.
package disp_window_driver_pkg;

  localparam int unsigned CNT_W = 14;
  localparam int unsigned PIX_W = 24;

  localparam logic [PIX_W-1:0] BG_COLOR_DEF = 24'h000000;
  localparam logic [PIX_W-1:0] UF_COLOR_DEF = 24'hFF00FF;

  localparam int unsigned H_TOTAL_1080P = 2200;
  localparam int unsigned H_SYNC_1080P  = 44;
  localparam int unsigned H_BP_1080P    = 148;
  localparam int unsigned H_VIS_1080P   = 1920;
  localparam int unsigned V_TOTAL_1080P = 1125;
  localparam int unsigned V_SYNC_1080P  = 5;
  localparam int unsigned V_BP_1080P    = 36;
  localparam int unsigned V_VIS_1080P   = 1080;

  // Index 0 is the left-most bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][PIX_W-1:0] BAR_TABLE = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[idx];
  endfunction

endpackage

// File: rtl/disp_timing_gen.sv
// Raster h/v counters with ext_sync restart; combinational sync, den and pixel coordinates.
module disp_timing_gen
  import disp_window_driver_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_1080P,
  parameter int unsigned H_SYNC  = H_SYNC_1080P,
  parameter int unsigned H_BP    = H_BP_1080P,
  parameter int unsigned H_VIS   = H_VIS_1080P,
  parameter bit          H_POL   = 1'b1,
  parameter int unsigned V_TOTAL = V_TOTAL_1080P,
  parameter int unsigned V_SYNC  = V_SYNC_1080P,
  parameter int unsigned V_BP    = V_BP_1080P,
  parameter int unsigned V_VIS   = V_VIS_1080P,
  parameter bit          V_POL   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_sync,
  output logic             hsync_c,
  output logic             vsync_c,
  output logic             den_c,
  output logic             frame_start_c,
  output logic [CNT_W-1:0] px_c,
  output logic [CNT_W-1:0] py_c
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_L = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END    = CNT_W'(H_SYNC + H_BP + H_VIS);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_SYNC_L = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END    = CNT_W'(V_SYNC + V_BP + V_VIS);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  assign frame_start_c = (h_cnt_q == '0) && (v_cnt_q == '0);

  // A restart pulse while already at the frame origin is ignored so the frame runs on undisturbed.
  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (ext_sync && !frame_start_c) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign hsync_c = (h_cnt_q < H_SYNC_L) ? H_POL : ~H_POL;
  assign vsync_c = (v_cnt_q < V_SYNC_L) ? V_POL : ~V_POL;
  assign den_c   = (h_cnt_q >= H_ACT) && (h_cnt_q < H_END) &&
                   (v_cnt_q >= V_ACT) && (v_cnt_q < V_END);
  assign px_c    = h_cnt_q - H_ACT;
  assign py_c    = v_cnt_q - V_ACT;

endmodule

// File: rtl/disp_window_driver.sv
// Places a SRC_H x SRC_V image read from a show-ahead FIFO at a per-frame origin in the raster.
// Colour-bar test pattern on test_mode is built only when DISP_TEST_PATTERN_EN is defined.
module disp_window_driver
  import disp_window_driver_pkg::*;
#(
  parameter int unsigned SRC_H    = 1024,
  parameter int unsigned SRC_V    = 1024,
  parameter int unsigned FIFO_W   = 32,
  parameter int unsigned H_TOTAL  = H_TOTAL_1080P,
  parameter int unsigned H_SYNC   = H_SYNC_1080P,
  parameter int unsigned H_BP     = H_BP_1080P,
  parameter int unsigned H_VIS    = H_VIS_1080P,
  parameter bit          H_POL    = 1'b1,
  parameter int unsigned V_TOTAL  = V_TOTAL_1080P,
  parameter int unsigned V_SYNC   = V_SYNC_1080P,
  parameter int unsigned V_BP     = V_BP_1080P,
  parameter int unsigned V_VIS    = V_VIS_1080P,
  parameter bit          V_POL    = 1'b1,
  parameter logic [23:0] BG_COLOR = BG_COLOR_DEF,
  parameter logic [23:0] UF_COLOR = UF_COLOR_DEF
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              ext_sync,
  input  logic [13:0]       win_x0,
  input  logic [13:0]       win_y0,
  input  logic              uf_clr,
  input  logic              test_mode,
  output logic              rd_load,
  output logic              rd_clk,
  output logic              rdfifo_rden,
  input  logic [FIFO_W-1:0] rdfifo_dout,
  input  logic              rdfifo_empty,
  output logic              video_hsync,
  output logic              video_vsync,
  output logic              video_den,
  output logic [23:0]       video_pixel,
  output logic              underflow,
  output logic [15:0]       uf_count
);

  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] SRC_H_L = SUM_W'(SRC_H);
  localparam logic [SUM_W-1:0] SRC_V_L = SUM_W'(SRC_V);

  logic             hsync_c, vsync_c, den_c, frame_start_c;
  logic [CNT_W-1:0] px_c, py_c;
  logic [SUM_W-1:0] x_end_c, y_end_c;
  logic             in_win_c, fifo_win_c, uf_evt_c;

  logic [CNT_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, den_q, den_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;
  logic             rd_load_q, rd_load_d;
  logic             underflow_q, underflow_d;
  logic [15:0]      uf_count_q, uf_count_d;
  logic             unused_dout_c;

  disp_timing_gen #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_BP(H_BP), .H_VIS(H_VIS), .H_POL(H_POL),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_BP(V_BP), .V_VIS(V_VIS), .V_POL(V_POL)
  ) u_timing (
    .clk          (pixel_clock),
    .reset        (reset),
    .ext_sync     (ext_sync),
    .hsync_c      (hsync_c),
    .vsync_c      (vsync_c),
    .den_c        (den_c),
    .frame_start_c(frame_start_c),
    .px_c         (px_c),
    .py_c         (py_c)
  );

  // Window bounds use one extra bit so an origin near the top of the range cannot wrap.
  assign x_end_c  = SUM_W'(x0_q) + SRC_H_L;
  assign y_end_c  = SUM_W'(y0_q) + SRC_V_L;
  assign in_win_c = den_c &&
                    (px_c >= x0_q) && (SUM_W'(px_c) < x_end_c) &&
                    (py_c >= y0_q) && (SUM_W'(py_c) < y_end_c);

`ifdef DISP_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (SRC_H >= 8) ? SRC_H / 8 : 1;
  logic [CNT_W-1:0] bar_quot_c;
  logic [2:0]       bar_idx_c;
  assign bar_quot_c = (px_c - x0_q) / CNT_W'(BAR_W);
  assign bar_idx_c  = (bar_quot_c > CNT_W'(7)) ? 3'd7 : bar_quot_c[2:0];
  assign fifo_win_c = in_win_c & ~test_mode;
`else
  logic unused_test_mode_c;
  assign unused_test_mode_c = test_mode;
  assign fifo_win_c         = in_win_c;
`endif

  assign uf_evt_c      = fifo_win_c & rdfifo_empty;
  assign rdfifo_rden   = fifo_win_c & ~rdfifo_empty & ~reset;
  assign unused_dout_c = ^rdfifo_dout;

  always_comb begin
    x0_d        = x0_q;
    y0_d        = y0_q;
    hsync_d     = hsync_c;
    vsync_d     = vsync_c;
    den_d       = den_c;
    rd_load_d   = frame_start_c;
    underflow_d = underflow_q;
    uf_count_d  = uf_count_q;
    pixel_d     = BG_COLOR;

    if (frame_start_c) begin
      x0_d = win_x0;
      y0_d = win_y0;
    end

    if (fifo_win_c) pixel_d = rdfifo_empty ? UF_COLOR : rdfifo_dout[FIFO_W-1 -: PIX_W];
`ifdef DISP_TEST_PATTERN_EN
    else if (in_win_c) pixel_d = bar_color(bar_idx_c);
`endif

    // Underflow set beats uf_clr; frame-start clear of the count beats a same-cycle increment.
    if (uf_clr)   underflow_d = 1'b0;
    if (uf_evt_c) underflow_d = 1'b1;
    if (uf_evt_c && (uf_count_q != 16'hFFFF)) uf_count_d = uf_count_q + 16'd1;
    if (frame_start_c) uf_count_d = '0;
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      x0_q        <= '0;
      y0_q        <= '0;
      hsync_q     <= ~H_POL;
      vsync_q     <= ~V_POL;
      den_q       <= 1'b0;
      pixel_q     <= '0;
      rd_load_q   <= 1'b0;
      underflow_q <= 1'b0;
      uf_count_q  <= '0;
    end else begin
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      den_q       <= den_d;
      pixel_q     <= pixel_d;
      rd_load_q   <= rd_load_d;
      underflow_q <= underflow_d;
      uf_count_q  <= uf_count_d;
    end
  end

  assign rd_clk      = pixel_clock;
  assign rd_load     = rd_load_q;
  assign video_hsync = hsync_q;
  assign video_vsync = vsync_q;
  assign video_den   = den_q;
  assign video_pixel = pixel_q;
  assign underflow   = underflow_q;
  assign uf_count    = uf_count_q;

endmodule
